// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states and buffer entry layout.
package fetch_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Memory, decode and redirect signals of the fetch unit bundled as one interface.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] instr_pcplus4;
  logic            instr_ready;

  logic            redirect;
  logic [XLEN-1:0] redirect_target;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pcplus4,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pcplus4,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect, redirect_target
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small instruction buffer: DEPTH entries of {pc, instr}, flush clears everything.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               push_data,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, redirect flush, small decode buffer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] req_pc;
  logic [CW-1:0]   count;
  logic            issue;
  logic            fire;
  logic            push;
  logic            pop;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  always_comb begin
    issue      = 1'b0;
    fire       = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    state_next = state;
    issue = (state == RUN) && (count < CW'(DEPTH)) && !bus.redirect && !reset;
    fire  = issue && bus.imem_gnt;
    push  = (state == WAIT) && bus.imem_rvalid && !bus.redirect;
    pop   = (count != CW'(0)) && bus.instr_ready && !bus.redirect;
    case (state)
      RUN: begin
        if (fire) state_next = WAIT;
        else      state_next = RUN;
      end
      // A response always closes the transaction; redirect only decides its fate.
      WAIT: begin
        if (bus.imem_rvalid)   state_next = RUN;
        else if (bus.redirect) state_next = DISCARD;
        else                   state_next = WAIT;
      end
      DISCARD: begin
        if (bus.imem_rvalid) state_next = RUN;
        else                 state_next = DISCARD;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      fpc    <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      state <= state_next;
      if (fire) req_pc <= fpc;
      if (bus.redirect) fpc <= word_align(bus.redirect_target);
      else if (fire)    fpc <= fpc + 32'd4;
    end
  end

  assign push_data = '{pc: req_pc, instr: bus.imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (bus.redirect),
    .push_data (push_data),
    .head      (head),
    .count     (count)
  );

  assign bus.imem_req      = issue;
  assign bus.imem_addr     = fpc;
  assign bus.instr_valid   = (count != CW'(0));
  assign bus.instr         = head.instr;
  assign bus.instr_pc      = head.pc;
  assign bus.instr_pcplus4 = head.pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios plus random traffic checked against a queue-based fetch model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic clk;
  logic reset;

  fetch_unit_if ifc ();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: fetch address, outstanding-request kind, buffered entries.
  logic [31:0] m_fpc;
  logic [31:0] m_reqpc;
  int          m_out;            // 0 none, 1 outstanding kept, 2 outstanding dropped
  logic [31:0] q_pc [$];
  logic [31:0] q_ins [$];
  bit          e_req;
  int          mem_cnt;          // memory responder countdown
  int          mem_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fpc   = RESET_PC;
    m_reqpc = RESET_PC;
    m_out   = 0;
    q_pc.delete();
    q_ins.delete();
  endtask

  task automatic model_step();
    bit fire, popv, pushv;
    fire = e_req && ifc.imem_gnt;
    if (mem_cnt > 0) mem_cnt--;
    if (fire) mem_cnt = mem_lat;
    if (reset) begin
      model_reset();
    end else begin
      popv  = (q_pc.size() != 0) && ifc.instr_ready && !ifc.redirect;
      pushv = (m_out == 1) && ifc.imem_rvalid && !ifc.redirect;
      if (ifc.redirect) begin
        q_pc.delete();
        q_ins.delete();
      end else begin
        if (popv) begin
          void'(q_pc.pop_front());
          void'(q_ins.pop_front());
        end
        if (pushv) begin
          q_pc.push_back(m_reqpc);
          q_ins.push_back(ifc.imem_rdata);
        end
      end
      if (m_out == 0)             m_out = fire ? 1 : 0;
      else if (ifc.imem_rvalid)   m_out = 0;
      else if (ifc.redirect)      m_out = 2;
      if (fire) begin
        m_reqpc = m_fpc;
        m_fpc   = m_fpc + 32'd4;
      end
      if (ifc.redirect) m_fpc = ifc.redirect_target & 32'hFFFF_FFFC;
    end
  endtask

  // One clock: memory drives its response, outputs are checked, model advances on the edge.
  task automatic tick();
    ifc.imem_rvalid = (mem_cnt == 1);
    ifc.imem_rdata  = $urandom();
    #1;
    e_req = (m_out == 0) && (q_pc.size() < DEPTH) && !ifc.redirect && !reset;
    chk("imem_req",    {31'd0, ifc.imem_req},    {31'd0, e_req});
    chk("imem_addr",   ifc.imem_addr,            m_fpc);
    chk("instr_valid", {31'd0, ifc.instr_valid}, {31'd0, (q_pc.size() != 0)});
    if (q_pc.size() != 0) begin
      chk("instr",         ifc.instr,         q_ins[0]);
      chk("instr_pc",      ifc.instr_pc,      q_pc[0]);
      chk("instr_pcplus4", ifc.instr_pcplus4, q_pc[0] + 32'd4);
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic reset_phase();
    reset               = 1'b1;
    ifc.redirect        = 1'b0;
    ifc.redirect_target = 32'd0;
    ifc.imem_gnt        = 1'b0;
    ifc.instr_ready     = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
  endtask

  initial begin
    reset               = 1'b1;
    ifc.imem_gnt        = 1'b0;
    ifc.imem_rvalid     = 1'b0;
    ifc.imem_rdata      = 32'd0;
    ifc.instr_ready     = 1'b0;
    ifc.redirect        = 1'b0;
    ifc.redirect_target = 32'd0;
    mem_cnt             = 0;
    mem_lat             = 1;
    @(posedge clk);
    #1;
    model_reset();
    tick();
    chk("rst_valid", {31'd0, ifc.instr_valid}, 32'd0);
    chk("rst_addr",  ifc.imem_addr,            RESET_PC);

    // Streaming with one-cycle memory latency.
    reset_phase();
    ifc.imem_gnt = 1'b1;
    ifc.instr_ready = 1'b1;
    mem_lat = 1;
    tick(); tick();
    chk("s1_pc0", ifc.instr_pc, 32'h0);
    chk("s1_p40", ifc.instr_pcplus4, 32'h4);
    tick(); tick();
    chk("s1_pc4", ifc.instr_pc, 32'h4);
    chk("s1_p44", ifc.instr_pcplus4, 32'h8);
    tick(); tick();
    chk("s1_pc8", ifc.instr_pc, 32'h8);
    chk("s1_p48", ifc.instr_pcplus4, 32'hC);

    // Decode stalled: buffer fills, issue stops, then drains in order.
    reset_phase();
    ifc.imem_gnt = 1'b1;
    mem_lat = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("s2_req_full", {31'd0, ifc.imem_req}, 32'd0);
    chk("s2_pc_hold",  ifc.instr_pc, 32'h0);
    tick(); tick();
    chk("s2_req_full2", {31'd0, ifc.imem_req}, 32'd0);
    chk("s2_pc_hold2",  ifc.instr_pc, 32'h0);
    ifc.instr_ready = 1'b1;
    tick();
    chk("s2_pc4",    ifc.instr_pc,  32'h4);
    chk("s2_addr8",  ifc.imem_addr, 32'h8);
    chk("s2_resume", {31'd0, ifc.imem_req}, 32'd1);

    // Redirect while waiting; late response is dropped.
    reset_phase();
    ifc.imem_gnt = 1'b1;
    ifc.instr_ready = 1'b1;
    mem_lat = 3;
    tick();
    ifc.redirect = 1'b1;
    ifc.redirect_target = 32'h100;
    tick();
    ifc.redirect = 1'b0;
    mem_lat = 1;
    tick(); tick();
    chk("s3_empty", {31'd0, ifc.instr_valid}, 32'd0);
    chk("s3_addr",  ifc.imem_addr, 32'h100);
    tick(); tick();
    chk("s3_pc", ifc.instr_pc, 32'h100);

    // Redirect coincident with the response; target is word-aligned.
    reset_phase();
    ifc.imem_gnt = 1'b1;
    ifc.instr_ready = 1'b1;
    mem_lat = 1;
    tick();
    ifc.redirect = 1'b1;
    ifc.redirect_target = 32'h203;
    tick();
    ifc.redirect = 1'b0;
    chk("s4_addr",  ifc.imem_addr, 32'h200);
    chk("s4_empty", {31'd0, ifc.instr_valid}, 32'd0);
    tick();

    // Fetch address wraps past the top of the address space.
    reset_phase();
    ifc.imem_gnt = 1'b1;
    ifc.instr_ready = 1'b1;
    ifc.redirect = 1'b1;
    ifc.redirect_target = 32'hFFFF_FFFC;
    tick();
    ifc.redirect = 1'b0;
    tick();
    chk("s5_wrap_addr", ifc.imem_addr, 32'h0);
    tick();
    chk("s5_pc",     ifc.instr_pc,      32'hFFFF_FFFC);
    chk("s5_pcplus", ifc.instr_pcplus4, 32'h0);
    tick();

    // Reset while a request is outstanding; the stale response is ignored.
    reset_phase();
    ifc.imem_gnt = 1'b1;
    mem_lat = 3;
    tick();
    reset = 1'b1;
    tick();
    chk("s6_valid_rst", {31'd0, ifc.instr_valid}, 32'd0);
    chk("s6_req_rst",   {31'd0, ifc.imem_req},    32'd0);
    tick();
    reset = 1'b0;
    ifc.imem_gnt = 1'b0;
    tick();
    chk("s6_valid", {31'd0, ifc.instr_valid}, 32'd0);
    chk("s6_addr",  ifc.imem_addr, RESET_PC);
    chk("s6_req",   {31'd0, ifc.imem_req}, 32'd1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      ifc.imem_gnt        = ($urandom_range(0, 3) != 0);
      ifc.instr_ready     = $urandom_range(0, 1);
      ifc.redirect        = ($urandom_range(0, 15) == 0);
      ifc.redirect_target = $urandom();
      mem_lat             = $urandom_range(1, 3);
      reset               = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
